car_traffic: RTL and testbench



---
 rtl/car_traffic_if.sv | 31 +++
 rtl/car_traffic.sv | 123 ++++++++++++
 tb/tb_car_traffic.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/car_traffic_if.sv
// Control inputs and car-position outputs of the lane traffic generator.
// The slave modport is the generator; the master modport is its driver/observer.
interface car_traffic_if;
    logic       i_level_up;
    logic       i_restart;
    logic       i_freeze;
    logic [9:0] o_car_x1;
    logic [9:0] o_car_x2;
    logic [9:0] o_car_x3;
    logic [9:0] o_car_x4;
    logic [9:0] o_car_x5;
    logic [9:0] o_car_x6;
    logic [9:0] o_car_x7;
    logic [9:0] o_car_x8;
    logic [2:0] o_level;
    logic       o_tick;

    modport slave (
        input  i_level_up, i_restart, i_freeze,
        output o_car_x1, o_car_x2, o_car_x3, o_car_x4,
               o_car_x5, o_car_x6, o_car_x7, o_car_x8,
               o_level, o_tick
    );

    modport master (
        output i_level_up, i_restart, i_freeze,
        input  o_car_x1, o_car_x2, o_car_x3, o_car_x4,
               o_car_x5, o_car_x6, o_car_x7, o_car_x8,
               o_level, o_tick
    );
endinterface

// File: rtl/car_traffic.sv
// Eight-lane car traffic generator: prescaled motion tick, per-lane speed and
// direction, wrap through an off-screen margin, level speed-up and restart.
module car_traffic #(
    parameter int TICK_DIV  = 250000,
    parameter int WRAP      = 704,
    parameter int SPACING   = 88,
    parameter int BASE_STEP = 1,
    parameter int MAX_LEVEL = 7
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    car_traffic_if.slave  bus
);
    localparam int NLANE = 8;

    logic [23:0] r_cnt;
    logic [23:0] w_cnt_nxt;
    logic [9:0]  r_x       [NLANE];
    logic [9:0]  w_x_nxt   [NLANE];
    logic [2:0]  r_level;
    logic [2:0]  w_level_nxt;
    logic        r_tick;
    logic        w_tick_nxt;
    logic        w_tick_ev;

    function automatic logic [9:0] f_start(input int lane);
        return 10'(lane * SPACING);
    endfunction

    function automatic logic [4:0] f_step(input int lane, input logic [2:0] lvl);
        return 5'(BASE_STEP) + 5'(lane % 4) + {2'b00, lvl};
    endfunction

    // 11-bit wrap arithmetic keeps every position inside [0, WRAP)
    function automatic logic [9:0] f_move(input logic [9:0] x, input logic [4:0] step,
                                          input logic dir_left);
        logic [10:0] w_x11;
        logic [10:0] w_s11;
        logic [10:0] w_nx;
        w_x11 = {1'b0, x};
        w_s11 = {6'b000000, step};
        if (dir_left) begin
            if (w_x11 < w_s11) begin
                w_nx = w_x11 + 11'(WRAP) - w_s11;
            end else begin
                w_nx = w_x11 - w_s11;
            end
        end else begin
            w_nx = w_x11 + w_s11;
            if (w_nx >= 11'(WRAP)) begin
                w_nx = w_nx - 11'(WRAP);
            end else begin
                w_nx = w_nx;
            end
        end
        return w_nx[9:0];
    endfunction

    // Next-state: restart beats freeze, freeze beats motion; level-up survives freeze
    always_comb begin
        w_tick_ev   = (r_cnt == 24'(TICK_DIV - 1));
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_tick_nxt  = 1'b0;
        for (int i = 0; i < NLANE; i++) begin
            w_x_nxt[i] = r_x[i];
        end
        if (bus.i_restart) begin
            w_cnt_nxt   = 24'd0;
            w_level_nxt = 3'd0;
            for (int i = 0; i < NLANE; i++) begin
                w_x_nxt[i] = f_start(i);
            end
        end else begin
            if (bus.i_freeze) begin
                w_tick_nxt = 1'b0;
            end else if (w_tick_ev) begin
                w_cnt_nxt  = 24'd0;
                w_tick_nxt = 1'b1;
                for (int i = 0; i < NLANE; i++) begin
                    w_x_nxt[i] = f_move(r_x[i], f_step(i, r_level), i[0]);
                end
            end else begin
                w_cnt_nxt = r_cnt + 24'd1;
            end
            if (bus.i_level_up && (r_level < 3'(MAX_LEVEL))) begin
                w_level_nxt = r_level + 3'd1;
            end else begin
                w_level_nxt = r_level;
            end
        end
    end

    // State registers with asynchronous return to the start pattern
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= 24'd0;
            r_level <= 3'd0;
            r_tick  <= 1'b0;
            for (int i = 0; i < NLANE; i++) begin
                r_x[i] <= f_start(i);
            end
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_tick  <= w_tick_nxt;
            for (int i = 0; i < NLANE; i++) begin
                r_x[i] <= w_x_nxt[i];
            end
        end
    end

    assign bus.o_car_x1 = r_x[0];
    assign bus.o_car_x2 = r_x[1];
    assign bus.o_car_x3 = r_x[2];
    assign bus.o_car_x4 = r_x[3];
    assign bus.o_car_x5 = r_x[4];
    assign bus.o_car_x6 = r_x[5];
    assign bus.o_car_x7 = r_x[6];
    assign bus.o_car_x8 = r_x[7];
    assign bus.o_level  = r_level;
    assign bus.o_tick   = r_tick;
endmodule

// File: tb/tb_car_traffic.sv
// Scoreboard bench for car_traffic: a modulo-arithmetic lane model predicts each
// tick's positions; a monitor pops and compares whenever the DUT raises TICK.
module tb_car_traffic;
    localparam int TICK_DIV  = 4;
    localparam int WRAP      = 704;
    localparam int SPACING   = 88;
    localparam int BASE_STEP = 1;
    localparam int MAX_LEVEL = 7;

    typedef struct {
        int x [8];
        int lvl;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    car_traffic_if bus();

    car_traffic #(
        .TICK_DIV(TICK_DIV), .WRAP(WRAP), .SPACING(SPACING),
        .BASE_STEP(BASE_STEP), .MAX_LEVEL(MAX_LEVEL)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_pass = 0;
    bit    mon_en = 1'b0;
    snap_t q [$];

    int m_x [8];
    int m_level;
    int m_cnt;
    int start_tab [8] = '{0, 88, 176, 264, 352, 440, 528, 616};
    int first_tab [8] = '{1, 86, 179, 260, 353, 438, 531, 612};

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int get_x(input int i);
        case (i)
            0: return int'(bus.o_car_x1);
            1: return int'(bus.o_car_x2);
            2: return int'(bus.o_car_x3);
            3: return int'(bus.o_car_x4);
            4: return int'(bus.o_car_x5);
            5: return int'(bus.o_car_x6);
            6: return int'(bus.o_car_x7);
            7: return int'(bus.o_car_x8);
            default: return -1;
        endcase
    endfunction

    task automatic model_init();
        for (int i = 0; i < 8; i++) m_x[i] = i * SPACING;
        m_level = 0;
        m_cnt   = 0;
    endtask

    // Reference: state after the next rising edge, given the inputs for that edge
    task automatic model_step(input bit lu, input bit rs, input bit fr);
        snap_t s;
        if (rs) begin
            model_init();
        end else begin
            if (!fr) begin
                if (m_cnt == TICK_DIV - 1) begin
                    m_cnt = 0;
                    for (int i = 0; i < 8; i++) begin
                        int step = BASE_STEP + (i % 4) + m_level;
                        if (i % 2 == 0) m_x[i] = (m_x[i] + step) % WRAP;
                        else            m_x[i] = (m_x[i] - step + WRAP) % WRAP;
                    end
                    if (lu && m_level < MAX_LEVEL) m_level++;
                    for (int i = 0; i < 8; i++) s.x[i] = m_x[i];
                    s.lvl = m_level;
                    q.push_back(s);
                    return;
                end
                m_cnt++;
            end
            if (lu && m_level < MAX_LEVEL) m_level++;
        end
    endtask

    task automatic cycle(input bit lu, input bit rs, input bit fr);
        @(negedge clk);
        bus.i_level_up = lu;
        bus.i_restart  = rs;
        bus.i_freeze   = fr;
        model_step(lu, rs, fr);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n          = 1'b1;
        bus.i_level_up = 1'b0;
        bus.i_restart  = 1'b0;
        bus.i_freeze   = 1'b0;
        q.delete();
        model_init();
        model_step(1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
    endtask

    task automatic chk_start(input string nm);
        for (int i = 0; i < 8; i++) chk($sformatf("%s_x%0d", nm, i + 1), get_x(i), start_tab[i]);
        chk({nm, "_level"}, int'(bus.o_level), 0);
        chk({nm, "_tick"}, int'(bus.o_tick), 0);
    endtask

    // Monitor: every DUT tick must match the oldest predicted tick
    always @(negedge clk) begin
        if (mon_en && rst_n && bus.o_tick) begin
            chk("tick_expected", (q.size() > 0) ? 1 : 0, 1);
            if (q.size() > 0) begin
                snap_t s;
                s = q.pop_front();
                for (int i = 0; i < 8; i++) chk($sformatf("tick_x%0d", i + 1), get_x(i), s.x[i]);
                chk("tick_level", int'(bus.o_level), s.lvl);
            end
        end
    end

    initial begin
        int frz_left;
        int saved [8];
        bus.i_level_up = 1'b0;
        bus.i_restart  = 1'b0;
        bus.i_freeze   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_start("reset");

        release_reset();
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        chk("first_tick", int'(bus.o_tick), 1);
        for (int i = 0; i < 8; i++) chk($sformatf("first_x%0d", i + 1), get_x(i), first_tab[i]);

        // Level-up on a tick edge: motion uses the old level
        cycle(1'b0, 1'b1, 1'b0);
        while (m_cnt != TICK_DIV - 1) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("lvl_tick_x1", int'(bus.o_car_x1), 1);
        chk("lvl_tick_level", int'(bus.o_level), 1);
        while (m_cnt != TICK_DIV - 1) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("lvl2_x1", int'(bus.o_car_x1), 3);

        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("level_sat", int'(bus.o_level), MAX_LEVEL);

        // Freeze with a level-up in the middle
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) saved[i] = m_x[i];
        for (int k = 0; k < 20; k++) begin
            cycle(k == 5, 1'b0, 1'b1);
            chk("frz_tick", int'(bus.o_tick), 0);
            chk("frz_x1", int'(bus.o_car_x1), saved[0]);
            chk("frz_x4", int'(bus.o_car_x4), saved[3]);
        end
        cycle(1'b0, 1'b0, 1'b0);
        chk("frz_level", int'(bus.o_level), 1);
        repeat (12) cycle(1'b0, 1'b0, 1'b0);

        // Lane 1 walks to the right edge and wraps to 0
        cycle(1'b0, 1'b1, 1'b0);
        while (m_x[0] != 703) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("rwrap_703", int'(bus.o_car_x1), 703);
        while (m_x[0] != 0) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("rwrap_0", int'(bus.o_car_x1), 0);

        frz_left = 0;
        for (int k = 0; k < 3000; k++) begin
            bit fr;
            if (frz_left > 0) begin
                fr = 1'b1;
                frz_left--;
            end else begin
                fr = 1'b0;
                if ($urandom % 40 == 0) frz_left = int'($urandom_range(1, 25));
            end
            cycle(($urandom % 8) == 0, ($urandom % 300) == 0, fr);
        end

        // Restart wins over a coincident tick and level-up
        while (m_cnt != TICK_DIV - 1) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk_start("restart");

        // Asynchronous reset right after a tick edge, checked before any clock edge
        cycle(1'b1, 1'b0, 1'b0);
        while (m_cnt != TICK_DIV - 1) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_start("async_rst");
        release_reset();
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        chk("rst_first_tick", int'(bus.o_tick), 1);
        repeat (9) cycle(1'b0, 1'b0, 1'b0);

        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
